// File: rtl/instruction_prefetch_buffer_if.sv
// rtl/instruction_prefetch_buffer_if.sv - cache fetch and decode delivery signals of the prefetch buffer
interface instruction_prefetch_buffer_if;
  logic [31:0]  InstructionAddress;
  logic         InstructionRequest;
  logic         InstructionWait;
  logic [127:0] InstructionIn;
  logic         ChangePC;
  logic [31:0]  NewPC;
  logic         DecoderReady;
  logic         InstructionValid;
  logic [31:0]  Instruction;
  logic [31:0]  InstructionPC;

  modport master (
    output InstructionAddress, InstructionRequest, InstructionValid, Instruction, InstructionPC,
    input  InstructionWait, InstructionIn, ChangePC, NewPC, DecoderReady
  );

  modport slave (
    input  InstructionAddress, InstructionRequest, InstructionValid, Instruction, InstructionPC,
    output InstructionWait, InstructionIn, ChangePC, NewPC, DecoderReady
  );
endinterface

// File: rtl/instruction_prefetch_buffer.sv
// rtl/instruction_prefetch_buffer.sv - line prefetch FIFO between instruction cache and decode
// Fetches 128-bit lines, delivers one word per cycle, and flushes/restarts on PC redirects.
module instruction_prefetch_buffer #(
  parameter int unsigned DEPTH        = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic                          clock,
  input logic                          reset,
  instruction_prefetch_buffer_if.master bus
);
  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_MISS  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [127:0]  line_q     [DEPTH];
  logic [27:0]   lineaddr_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [27:0]   fetch_line_q, fetch_line_d;
  logic [1:0]    rd_word_q, rd_word_d;
  logic [1:0]    state_q, state_d;
  logic [31:2]   redir_pc_q, redir_pc_d;

  logic req, fill, pop, frees, valid, not_empty;
  logic unused_newpc_bits;

  assign unused_newpc_bits = ^bus.NewPC[1:0];
  assign not_empty = (count_q != '0);

  // Outside RUN the request stays up so the refill keeps seeing a stable address.
  assign req   = (state_q != ST_RUN) || ((count_q < DEPTH_C) && !bus.ChangePC);
  assign fill  = !bus.InstructionWait &&
                 (((state_q == ST_RUN) && req) || ((state_q == ST_MISS) && !bus.ChangePC));
  assign valid = not_empty && !bus.ChangePC && (state_q != ST_DRAIN);
  assign pop   = valid && bus.DecoderReady;
  assign frees = pop && (rd_word_q == 2'd3);

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    fetch_line_d = fetch_line_q;
    rd_word_d    = rd_word_q;
    redir_pc_d   = redir_pc_q;

    if (pop) begin
      rd_word_d = rd_word_q + 2'd1;
      if (frees) head_d = head_q + 1'b1;
    end
    if (fill) begin
      tail_d       = tail_q + 1'b1;
      fetch_line_d = fetch_line_q + 28'd1;
    end
    count_d = count_q + CW'(fill) - CW'(frees);

    case (state_q)
      ST_RUN: begin
        if (bus.ChangePC) begin
          head_d       = '0;
          tail_d       = '0;
          count_d      = '0;
          fetch_line_d = bus.NewPC[31:4];
          rd_word_d    = bus.NewPC[3:2];
        end else if (req && bus.InstructionWait) begin
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        if (bus.ChangePC) begin
          state_d    = ST_DRAIN;
          redir_pc_d = bus.NewPC[31:2];
          head_d     = '0;
          tail_d     = '0;
          count_d    = '0;
        end else if (!bus.InstructionWait) begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (bus.ChangePC) redir_pc_d = bus.NewPC[31:2];
        // The refill completing here belongs to the abandoned stream; drop it and restart.
        if (!bus.InstructionWait) begin
          fetch_line_d = redir_pc_d[31:4];
          rd_word_d    = redir_pc_d[3:2];
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      fetch_line_q <= RESET_VECTOR[31:4];
      rd_word_q    <= RESET_VECTOR[3:2];
      state_q      <= ST_RUN;
      redir_pc_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      fetch_line_q <= fetch_line_d;
      rd_word_q    <= rd_word_d;
      state_q      <= state_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  // Entry payloads need no reset: they are only observed while count_q covers them.
  always_ff @(posedge clock) begin
    if (fill) begin
      line_q[tail_q]     <= bus.InstructionIn;
      lineaddr_q[tail_q] <= fetch_line_q;
    end
  end

  assign bus.InstructionAddress = {fetch_line_q, 4'b0000};
  assign bus.InstructionRequest = req && reset;
  assign bus.InstructionValid   = valid;
  assign bus.Instruction        = not_empty ? line_q[head_q][{rd_word_q, 5'b00000} +: 32] : 32'h0;
  assign bus.InstructionPC      = not_empty ? {lineaddr_q[head_q], rd_word_q, 2'b00} : 32'h0;
endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// tb/tb_instruction_prefetch_buffer.sv - directed and randomized checks of instruction_prefetch_buffer
module tb_instruction_prefetch_buffer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  instruction_prefetch_buffer_if bus ();

  instruction_prefetch_buffer #(.DEPTH(2), .RESET_VECTOR(32'h0000_0000)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Cache contents: line 0 reads 00000000,11111111,22222222,33333333; every word unique.
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return (32'h1111_1111 * {30'd0, pc[3:2]}) ^ {pc[31:4], 4'h0};
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++)
      bus.InstructionIn[32*k +: 32] = word_at({bus.InstructionAddress[31:4], 4'(k * 4)});
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.InstructionWait = 1'b0;
    bus.ChangePC        = 1'b0;
    bus.NewPC           = 32'h0;
    bus.DecoderReady    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    for (int c = 0; c < 3; c++) begin
      bus.DecoderReady = (c != 0);
      settle();
      checks++;
      if ({bus.InstructionRequest, bus.InstructionValid, bus.Instruction, bus.InstructionPC,
           bus.InstructionAddress} !== 98'h0) begin
        errors++;
        $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h addr=%h expected all zero",
                 bus.InstructionRequest, bus.InstructionValid, bus.Instruction,
                 bus.InstructionPC, bus.InstructionAddress);
      end
      cyc();
    end
  endtask

  task automatic test_miss_refill();
    logic [64:0] exp;
    do_reset();
    bus.InstructionWait = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.InstructionWait = 1'b0;
      settle();
      checks++;
      if ({bus.InstructionRequest, bus.InstructionAddress, bus.InstructionValid} !== {1'b1, 32'h0, 1'b0}) begin
        errors++;
        $display("FAIL miss_hold c=%0d: req=%b addr=%h valid=%b expected req=1 addr=0 valid=0",
                 c, bus.InstructionRequest, bus.InstructionAddress, bus.InstructionValid);
      end
      cyc();
    end
    bus.DecoderReady = 1'b1;
    for (int w = 0; w < 4; w++) begin
      settle();
      exp = {1'b1, 32'(w * 4), 32'(32'h1111_1111 * w)};
      checks++;
      if ({bus.InstructionValid, bus.InstructionPC, bus.Instruction} !== exp) begin
        errors++;
        $display("FAIL refill_word w=%0d: got %h expected %h", w,
                 {bus.InstructionValid, bus.InstructionPC, bus.Instruction}, exp);
      end
      if (w == 0) begin
        checks++;
        if ({bus.InstructionRequest, bus.InstructionAddress} !== {1'b1, 32'h10}) begin
          errors++;
          $display("FAIL next_line_addr: req=%b addr=%h expected req=1 addr=00000010",
                   bus.InstructionRequest, bus.InstructionAddress);
        end
      end
      cyc();
    end
    bus.DecoderReady = 1'b0;
  endtask

  task automatic test_full_buffer();
    logic [32:0] exp_a;
    logic [33:0] exp_b;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      settle();
      exp_a = {1'b1, 32'(c * 16)};
      checks++;
      if ({bus.InstructionRequest, bus.InstructionAddress} !== exp_a) begin
        errors++;
        $display("FAIL fill_addr c=%0d: got %h expected %h", c,
                 {bus.InstructionRequest, bus.InstructionAddress}, exp_a);
      end
      cyc();
    end
    for (int c = 0; c < 7; c++) begin
      if (c == 3) bus.DecoderReady = 1'b1;
      settle();
      exp_b = {1'b0, 1'b1, (c < 3) ? 32'h0 : 32'((c - 3) * 4)};
      checks++;
      if ({bus.InstructionRequest, bus.InstructionValid, bus.InstructionPC} !== exp_b) begin
        errors++;
        $display("FAIL full_hold c=%0d: got %h expected %h", c,
                 {bus.InstructionRequest, bus.InstructionValid, bus.InstructionPC}, exp_b);
      end
      cyc();
    end
    bus.DecoderReady = 1'b0;
    settle();
    checks++;
    if ({bus.InstructionRequest, bus.InstructionAddress, bus.InstructionValid, bus.InstructionPC} !==
        {1'b1, 32'h20, 1'b1, 32'h10}) begin
      errors++;
      $display("FAIL refetch_after_free: req=%b addr=%h valid=%b pc=%h expected 1 00000020 1 00000010",
               bus.InstructionRequest, bus.InstructionAddress, bus.InstructionValid, bus.InstructionPC);
    end
  endtask

  task automatic test_redirect_run();
    logic [64:0] exp;
    cyc();
    settle();
    checks++;
    if (bus.InstructionRequest !== 1'b0) begin
      errors++;
      $display("FAIL full_no_request: req=%b expected 0", bus.InstructionRequest);
    end
    bus.ChangePC     = 1'b1;
    bus.NewPC        = 32'h0000_0108;
    bus.DecoderReady = 1'b1;
    settle();
    checks++;
    if ({bus.InstructionValid, bus.InstructionRequest} !== 2'b00) begin
      errors++;
      $display("FAIL redirect_cycle: valid=%b req=%b expected 0 0",
               bus.InstructionValid, bus.InstructionRequest);
    end
    cyc();
    bus.ChangePC = 1'b0;
    settle();
    checks++;
    if ({bus.InstructionValid, bus.InstructionRequest, bus.InstructionAddress} !== {2'b01, 32'h100}) begin
      errors++;
      $display("FAIL redirect_fetch: valid=%b req=%b addr=%h expected 0 1 00000100",
               bus.InstructionValid, bus.InstructionRequest, bus.InstructionAddress);
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      settle();
      exp = {1'b1, 32'(32'h108 + i * 4), word_at(32'(32'h108 + i * 4))};
      checks++;
      if ({bus.InstructionValid, bus.InstructionPC, bus.Instruction} !== exp) begin
        errors++;
        $display("FAIL redirect_stream i=%0d: got %h expected %h", i,
                 {bus.InstructionValid, bus.InstructionPC, bus.Instruction}, exp);
      end
      cyc();
    end
  endtask

  task automatic test_redirect_miss();
    bus.DecoderReady = 1'b0;
    bus.ChangePC     = 1'b1;
    bus.NewPC        = 32'h0000_0040;
    settle();
    cyc();
    bus.ChangePC        = 1'b0;
    bus.InstructionWait = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.ChangePC = (c == 1);
      bus.NewPC    = (c == 1) ? 32'h0000_0200 : 32'h0000_0000;
      if (c == 5) bus.InstructionWait = 1'b0;
      settle();
      checks++;
      if ({bus.InstructionRequest, bus.InstructionAddress, bus.InstructionValid} !== {1'b1, 32'h40, 1'b0}) begin
        errors++;
        $display("FAIL drain_hold c=%0d: req=%b addr=%h valid=%b expected 1 00000040 0", c,
                 bus.InstructionRequest, bus.InstructionAddress, bus.InstructionValid);
      end
      cyc();
    end
    bus.ChangePC = 1'b0;
    settle();
    checks++;
    if ({bus.InstructionRequest, bus.InstructionAddress, bus.InstructionValid} !== {1'b1, 32'h200, 1'b0}) begin
      errors++;
      $display("FAIL drain_restart: req=%b addr=%h valid=%b expected 1 00000200 0",
               bus.InstructionRequest, bus.InstructionAddress, bus.InstructionValid);
    end
    bus.DecoderReady = 1'b1;
    cyc();
    settle();
    checks++;
    if ({bus.InstructionValid, bus.InstructionPC, bus.Instruction} !== {1'b1, 32'h200, word_at(32'h200)}) begin
      errors++;
      $display("FAIL drain_first_word: valid=%b pc=%h instr=%h expected 1 00000200 %h",
               bus.InstructionValid, bus.InstructionPC, bus.Instruction, word_at(32'h200));
    end
    cyc();
    bus.DecoderReady = 1'b0;
  endtask

  task automatic test_redirect_fill_pop();
    do_reset();
    bus.DecoderReady = 1'b1;
    settle();
    cyc();
    bus.ChangePC = 1'b1;
    bus.NewPC    = 32'hFFFF_FFF0;
    settle();
    checks++;
    if ({bus.InstructionValid, bus.InstructionRequest} !== 2'b00) begin
      errors++;
      $display("FAIL fillpop_redirect: valid=%b req=%b expected 0 0",
               bus.InstructionValid, bus.InstructionRequest);
    end
    cyc();
    bus.ChangePC = 1'b0;
    settle();
    checks++;
    if ({bus.InstructionValid, bus.InstructionRequest, bus.InstructionAddress} !== {2'b01, 32'hFFFF_FFF0}) begin
      errors++;
      $display("FAIL fillpop_flushed: valid=%b req=%b addr=%h expected 0 1 fffffff0",
               bus.InstructionValid, bus.InstructionRequest, bus.InstructionAddress);
    end
    cyc();
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({bus.InstructionValid, bus.InstructionPC, bus.Instruction} !==
          {1'b1, 32'(32'hFFFF_FFF0 + i * 4), word_at(32'(32'hFFFF_FFF0 + i * 4))}) begin
        errors++;
        $display("FAIL wrap_stream i=%0d: valid=%b pc=%h instr=%h", i,
                 bus.InstructionValid, bus.InstructionPC, bus.Instruction);
      end
      if (i == 0) begin
        checks++;
        if (bus.InstructionAddress !== 32'h0) begin
          errors++;
          $display("FAIL wrap_addr: addr=%h expected 00000000", bus.InstructionAddress);
        end
      end
      cyc();
    end
    bus.DecoderReady = 1'b0;
  endtask

  task automatic test_reset_in_miss();
    do_reset();
    bus.ChangePC = 1'b1;
    bus.NewPC    = 32'h0000_0300;
    settle();
    cyc();
    bus.ChangePC        = 1'b0;
    bus.InstructionWait = 1'b1;
    cyc();
    cyc();
    #2;
    reset               = 1'b0;
    bus.InstructionWait = 1'b0;
    #1;
    checks++;
    if ({bus.InstructionRequest, bus.InstructionValid, bus.Instruction, bus.InstructionPC,
         bus.InstructionAddress} !== 98'h0) begin
      errors++;
      $display("FAIL reset_mid_miss: req=%b valid=%b instr=%h pc=%h addr=%h expected all zero",
               bus.InstructionRequest, bus.InstructionValid, bus.Instruction,
               bus.InstructionPC, bus.InstructionAddress);
    end
    cyc();
    reset = 1'b1;
    settle();
    checks++;
    if ({bus.InstructionRequest, bus.InstructionAddress} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_release_addr: req=%b addr=%h expected 1 00000000",
               bus.InstructionRequest, bus.InstructionAddress);
    end
    cyc();
    settle();
    checks++;
    if ({bus.InstructionValid, bus.InstructionPC, bus.Instruction} !== {1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_release_word: valid=%b pc=%h instr=%h expected 1 00000000 00000000",
               bus.InstructionValid, bus.InstructionPC, bus.Instruction);
    end
  endtask

  // Reference: the decoder must see a gap-free PC stream restarting at each redirect target,
  // each word matching cache contents, and a stalled request must keep its address.
  task automatic test_random_stream();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_stall;
    int          delivered;
    do_reset();
    exp_pc     = 32'h0;
    prev_addr  = 32'h0;
    prev_stall = 1'b0;
    delivered  = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.InstructionWait = ($urandom_range(0, 2) == 0);
      bus.DecoderReady    = ($urandom_range(0, 3) != 0);
      bus.ChangePC        = ($urandom_range(0, 19) == 0);
      bus.NewPC           = $urandom;
      settle();
      if (prev_stall) begin
        checks++;
        if ({bus.InstructionRequest, bus.InstructionAddress} !== {1'b1, prev_addr}) begin
          errors++;
          $display("FAIL rand_addr_hold c=%0d: req=%b addr=%h expected 1 %h", c,
                   bus.InstructionRequest, bus.InstructionAddress, prev_addr);
        end
      end
      if (bus.ChangePC) begin
        checks++;
        if (bus.InstructionValid !== 1'b0) begin
          errors++;
          $display("FAIL rand_valid_on_redirect c=%0d: valid=%b expected 0", c, bus.InstructionValid);
        end
        exp_pc = {bus.NewPC[31:2], 2'b00};
      end else if (bus.InstructionValid && bus.DecoderReady) begin
        checks++;
        if ({bus.InstructionPC, bus.Instruction} !== {exp_pc, word_at(exp_pc)}) begin
          errors++;
          $display("FAIL rand_stream c=%0d: pc=%h instr=%h expected %h %h", c,
                   bus.InstructionPC, bus.Instruction, exp_pc, word_at(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      prev_stall = bus.InstructionRequest && bus.InstructionWait;
      prev_addr  = bus.InstructionAddress;
      cyc();
    end
    idle();
    checks++;
    if (delivered < 300) begin
      errors++;
      $display("FAIL rand_throughput: delivered=%0d expected at least 300", delivered);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_miss_refill();
    test_full_buffer();
    test_redirect_run();
    test_redirect_miss();
    test_redirect_fill_pop();
    test_reset_in_miss();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
